sample_pack_fifo: RTL and testbench

SAMPLE_PACK_FIFO -- requirements
Module: sample_pack_fifo

---
 rtl/sample_pack_fifo_pkg.sv | 21 ++
 rtl/sample_pack_dpram.sv | 36 +++
 rtl/sample_pack_fifo.sv | 149 ++++++++++++++
 tb/tb_sample_pack_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_pack_fifo_pkg.sv
// Shared types and sizing helpers for the sample packer and its byte store.
package sample_pack_fifo_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PAD   = 2'd2
    } state_e;

    // Up to 15 residual bits can sit below a freshly placed sample.
    localparam int ACC_HEADROOM = 15;

    function automatic int acc_width(input int sample_w);
        return sample_w + ACC_HEADROOM;
    endfunction

    function automatic int cnt_width(input int sample_w);
        return $clog2(sample_w + ACC_HEADROOM + 1);
    endfunction

endpackage

// File: rtl/sample_pack_dpram.sv
// Simple dual-port DEPTH x 8 byte store with a registered synchronous read port.
// Read data appears one cycle after rd_en_i and holds between reads; no backpressure.
module sample_pack_dpram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_pack_fifo.sv
// Packs SAMPLE_W-bit samples LSB-first into bytes and buffers them in a byte FIFO.
// Read data one cycle after an accepted read; wr_ready drops when the bit accumulator backs up or a flush runs.
module sample_pack_fifo
    import sample_pack_fifo_pkg::*;
#(
    parameter int SAMPLE_W = 10,
    parameter int DEPTH    = 1024,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    output logic                wr_ready,
    input  logic                flush,
    output logic                flush_done,
    input  logic                rd_en,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                full,
    output logic [AW:0]         fill_count
);

    localparam int ACC_W = acc_width(SAMPLE_W);
    localparam int CW    = cnt_width(SAMPLE_W);

    localparam logic [CW-1:0] CNT_BYTE   = CW'(8);
    localparam logic [CW-1:0] CNT_LIMIT  = CW'(16);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_W);
    localparam logic [AW:0]   FILL_MAX   = (AW+1)'(DEPTH);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      fill_q, fill_d;
    logic             rd_valid_q;
    logic             flush_done_q;

    logic             pop, pad_wr, store_we, accept, rd_fire;
    logic [ACC_W-1:0] acc_shift, sample_ext;
    logic [CW-1:0]    cnt_shift;

    assign full       = (fill_q == FILL_MAX);
    assign empty      = (fill_q == '0);
    assign wr_ready   = (cnt_q < CNT_LIMIT) && (state_q == ST_RUN);
    assign accept     = wr_en && wr_ready;
    assign pop        = (cnt_q >= CNT_BYTE) && !full;
    // Bits above cnt_q are always zero, so the pad byte is simply acc_q[7:0].
    assign pad_wr     = (state_q == ST_PAD) && (cnt_q != '0) && !full;
    assign store_we   = pop || pad_wr;
    assign rd_fire    = rd_en && !empty;
    assign sample_ext = ACC_W'(wr_data);

    always_comb begin
        acc_shift = pop ? (acc_q >> 8) : acc_q;
        cnt_shift = pop ? (cnt_q - CNT_BYTE) : cnt_q;
        acc_d     = acc_shift;
        cnt_d     = cnt_shift;
        if (accept) begin
            acc_d = acc_shift | (sample_ext << cnt_shift);
            cnt_d = cnt_shift + CNT_SAMPLE;
        end
        if (pad_wr) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_comb begin
        fill_d = fill_q;
        case ({store_we, rd_fire})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            rd_valid_q <= rd_fire;
            if (store_we) wptr_q <= wptr_q + AW'(1);
            if (rd_fire)  rptr_q <= rptr_q + AW'(1);
        end
    end

    // Transitions look at the post-edge bit count so an empty flush finishes in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        if (cnt_d == '0) flush_done_q <= 1'b1;
                        else             state_q      <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_d == '0) begin
                        flush_done_q <= 1'b1;
                        state_q      <= ST_RUN;
                    end else if (cnt_d < CNT_BYTE) begin
                        state_q <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (cnt_d == '0) begin
                        flush_done_q <= 1'b1;
                        state_q      <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    sample_pack_dpram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_store (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en_i  (store_we),
        .wr_addr_i(wptr_q),
        .wr_data_i(acc_q[7:0]),
        .rd_en_i  (rd_fire),
        .rd_addr_i(rptr_q),
        .rd_data_o(rd_data)
    );

    assign fill_count = fill_q;
    assign rd_valid   = rd_valid_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_sample_pack_fifo.sv
// Bench for sample_pack_fifo: table of packing vectors plus multi-cycle corner sequences.
module tb_sample_pack_fifo;

    localparam int SW    = 10;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [SW-1:0] wr_data;
    logic          wr_ready;
    logic          flush;
    logic          flush_done;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   fill_count;

    sample_pack_fifo #(.SAMPLE_W(SW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .flush(flush), .flush_done(flush_done),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]          n;
        logic [3:0][SW-1:0]  s;
        logic                fl;
        logic [2:0]          nb;
        logic [5:0][7:0]     b;
    } vec_t;

    vec_t          vecs[7];
    logic [SW-1:0] wbuf[4];
    logic [7:0]    exp_q[$];
    bit            mbits[$];
    bit            use_model;
    bit            fill_over;
    logic [7:0]    mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_data", int'(rd_data), int'(mon_e));
            end
        end
        if (reset_n && (int'(fill_count) > DEPTH)) fill_over = 1'b1;
    end

    function automatic void model_emit();
        logic [7:0] b;
        while (mbits.size() >= 8) begin
            for (int j = 0; j < 8; j++) b[j] = mbits.pop_front();
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_push(input logic [SW-1:0] s);
        for (int i = 0; i < SW; i++) mbits.push_back(s[i]);
        model_emit();
    endfunction

    function automatic void model_pad();
        if (mbits.size() > 0) begin
            while (mbits.size() < 8) mbits.push_back(1'b0);
            model_emit();
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        wr_en = 1'b0; flush = 1'b0; rd_en = 1'b0;
        #1;
        check("rst_fill", int'(fill_count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_flush_done", int'(flush_done), 0);
        exp_q.delete();
        mbits.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_wr_ready", int'(wr_ready), 1);
        tick();
    endtask

    task automatic write_samples(input int n);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 50) begin
            wr_en = 1'b1;
            wr_data = wbuf[idx];
            @(negedge clk);
            if (wr_ready) begin
                if (use_model) model_push(wbuf[idx]);
                idx++;
            end
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        if (idx < n) check("write_timeout", idx, n);
    endtask

    task automatic do_flush(output int pulses, output int lat, output int rdy_hi);
        bit done = 1'b0;
        pulses = 0; lat = 0; rdy_hi = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (flush_done) begin
                pulses++;
                if (!done) lat = k;
                done = 1'b1;
            end else if (!done && wr_ready) begin
                rdy_hi++;
            end
            tick();
        end
        if (use_model) model_pad();
    endtask

    task automatic read_n(input int n);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n && cyc < 100) begin
            rd_en = 1'b1;
            @(negedge clk);
            if (!empty) cnt++;
            tick();
            cyc++;
        end
        rd_en = 1'b0;
        repeat (2) tick();
        if (cnt < n) check("read_timeout", cnt, n);
    endtask

    initial begin
        int pulses, lat, rdy_hi, acc, writes;
        bit ok;
        reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; rd_en = 1'b0;
        use_model = 1'b0; fill_over = 1'b0;

        vecs[0] = '{n: 3'd4, s: {10'h200, 10'h2DA, 10'h1BC, 10'h1AA}, fl: 1'b0, nb: 3'd5,
                    b: {8'h00, 8'h80, 8'h2D, 8'hA6, 8'hF1, 8'hAA}};
        vecs[1] = '{n: 3'd1, s: {30'h0, 10'h3FF}, fl: 1'b1, nb: 3'd2, b: {32'h0, 8'h03, 8'hFF}};
        vecs[2] = '{n: 3'd1, s: {30'h0, 10'h155}, fl: 1'b1, nb: 3'd2, b: {32'h0, 8'h01, 8'h55}};
        vecs[3] = '{n: 3'd0, s: 40'h0, fl: 1'b1, nb: 3'd0, b: 48'h0};
        vecs[4] = '{n: 3'd2, s: {20'h0, 10'h000, 10'h0FF}, fl: 1'b0, nb: 3'd2, b: {32'h0, 8'h00, 8'hFF}};
        vecs[5] = '{n: 3'd2, s: {20'h0, 10'h002, 10'h001}, fl: 1'b1, nb: 3'd3,
                    b: {24'h0, 8'h00, 8'h08, 8'h01}};
        vecs[6] = '{n: 3'd4, s: {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, fl: 1'b0, nb: 3'd5,
                    b: {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            use_model = 1'b0;
            for (int i = 0; i < int'(vecs[v].nb); i++) exp_q.push_back(vecs[v].b[i]);
            for (int i = 0; i < 4; i++) wbuf[i] = vecs[v].s[i];
            write_samples(int'(vecs[v].n));
            if (vecs[v].fl) begin
                do_flush(pulses, lat, rdy_hi);
                check("vec_flush_pulses", pulses, 1);
                check("vec_flush_wr_ready_low", rdy_hi, 0);
                if (vecs[v].n == 3'd0) check("vec_empty_flush_latency", lat, 1);
            end
            repeat (4) tick();
            check("vec_fill", int'(fill_count), int'(vecs[v].nb));
            read_n(int'(vecs[v].nb));
            check("vec_left", exp_q.size(), 0);
            check("vec_empty", int'(empty), 1);
        end

        // Continuous writes into a 16-byte store with no reads.
        do_reset();
        use_model = 1'b1;
        acc = 0;
        wr_data = 10'h155;
        for (int c = 0; c < 40; c++) begin
            wr_en = (acc < 20);
            @(negedge clk);
            if (wr_en && wr_ready) begin
                model_push(wr_data);
                acc++;
            end
            tick();
        end
        wr_en = 1'b0;
        @(negedge clk);
        check("full_accepted", acc, 15);
        check("full_wr_ready", int'(wr_ready), 0);
        check("full_flag", int'(full), 1);
        check("full_fill", int'(fill_count), 16);
        tick();
        read_n(18);
        @(negedge clk);
        check("full_drain_wr_ready", int'(wr_ready), 1);
        check("full_drain_fill", int'(fill_count), 0);
        check("full_drain_left", exp_q.size(), 0);
        tick();

        // Reads against an empty store, then a single-byte read latency check.
        do_reset();
        use_model = 1'b1;
        rd_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("empty_rd_valid", int'(rd_valid), 0);
            tick();
        end
        rd_en = 1'b0;
        wbuf[0] = 10'h0FF;
        write_samples(1);
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (!empty) ok = 1'b1;
            tick();
        end
        check("byte_ready", int'(ok), 1);
        rd_en = 1'b1;
        @(negedge clk);
        check("rd_valid_before", int'(rd_valid), 0);
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        check("rd_valid_lat", int'(rd_valid), 1);
        tick();
        @(negedge clk);
        check("rd_valid_drop", int'(rd_valid), 0);
        check("rd_data_hold", int'(rd_data), 8'hFF);
        tick();

        // Sustained random traffic checked against the bit-level model.
        do_reset();
        use_model = 1'b1;
        fill_over = 1'b0;
        writes = 0;
        for (int c = 0; c < 800; c++) begin
            wr_en = (writes < 200) && ($urandom_range(0, 3) != 0);
            wr_data = SW'($urandom);
            rd_en = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (wr_en && wr_ready) begin
                model_push(wr_data);
                writes++;
            end
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) tick();
        do_flush(pulses, lat, rdy_hi);
        check("sustain_flush_pulses", pulses, 1);
        check("sustain_fill", int'(fill_count), exp_q.size());
        read_n(exp_q.size());
        check("sustain_left", exp_q.size(), 0);
        check("sustain_fill_bound", int'(fill_over), 0);

        // Reset with 7 bytes stored and 6 residual bits.
        do_reset();
        use_model = 1'b1;
        wbuf[0] = 10'h3FF;
        for (int r = 0; r < 3; r++) begin
            write_samples(1);
            do_flush(pulses, lat, rdy_hi);
        end
        wbuf[0] = 10'h123; wbuf[1] = 10'h2AB; wbuf[2] = 10'h0F0;
        write_samples(3);
        repeat (4) tick();
        read_n(2);
        check("pre_reset_fill", int'(fill_count), 7);
        do_reset();
        wbuf[0] = 10'h0FF;
        write_samples(1);
        repeat (3) tick();
        check("post_reset_fill", int'(fill_count), 1);
        check("post_reset_exp", exp_q.size(), 1);
        read_n(1);
        check("post_reset_byte", int'(rd_data), 8'hFF);
        check("post_reset_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
